// File: rtl/uart_pkg.sv
// Shared types for the UART-side FIFO write path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RDY  = 2'd1,
    TRIGGER   = 2'd2,
    WAIT_DONE = 2'd3
  } FifoWrArbiter_state;

endpackage

// File: rtl/fifo_wr_arbiter_fsm.sv
// Handshake sequencer for the shared FIFO writer: grant, wait for room,
// trigger, wait for completion.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   IDLE      | no transfer; load a winner when any request is up
//   WAIT_RDY  | word latched; waiting for writer ready and FIFO room
//   TRIGGER   | wr_trigger held until the writer drops wr_rdy
//   WAIT_DONE | waiting for wr_done; acknowledge in that cycle
module fifo_wr_arbiter_fsm
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic any_req,
  input  logic wr_rdy,
  input  logic is_full,
  input  logic wr_done,
  output logic grant_load,
  output logic wr_trigger,
  output logic done_pulse,
  output logic busy
);

  FifoWrArbiter_state state, state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_load = 1'b0;
    wr_trigger = 1'b0;
    done_pulse = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_load = 1'b1;
          state_nxt  = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        busy = 1'b1;
        if (wr_rdy && !is_full) state_nxt = TRIGGER;
      end
      TRIGGER: begin
        // is_full is the writer's concern once triggered
        busy       = 1'b1;
        wr_trigger = 1'b1;
        if (!wr_rdy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (wr_done) begin
          done_pulse = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO writer among NUM_REQ byte producers.
// Holds the picker, the granted word/index latches and the rotation pointer.
module fifo_wr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  input  logic                       wr_rdy,
  input  logic                       wr_done,
  input  logic                       is_full,
  output logic                       wr_trigger,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             grant_load;
  logic             done_pulse;
  int               cand;

  // Search starts just past the last served requester; modulo keeps
  // non-power-of-two sizes wrapping correctly.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_idx) + k) % NUM_REQ;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_data  <= '0;
      cur_idx  <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (grant_load) begin
        wr_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
        cur_idx <= pick_idx;
      end
      if (done_pulse) last_idx <= cur_idx;
    end
  end

  assign ack = done_pulse ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cur_idx) : '0;

  fifo_wr_arbiter_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .any_req    (pick_valid),
    .wr_rdy     (wr_rdy),
    .is_full    (is_full),
    .wr_done    (wr_done),
    .grant_load (grant_load),
    .wr_trigger (wr_trigger),
    .done_pulse (done_pulse),
    .busy       (busy)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 2-requester instance with a slow
// writer model and a 3-requester instance for wrap-around ordering.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  ack;
  logic        wr_rdy = 1'b1, wr_done = 1'b0, is_full = 1'b0;
  logic        wr_trigger, busy;
  logic [7:0]  wr_data;
  logic [0:0]  cur_idx;

  logic [2:0]  req3 = '0;
  logic [23:0] req_data3 = '0;
  logic [2:0]  ack3;
  logic        wr_rdy3 = 1'b1, wr_done3 = 1'b0, is_full3 = 1'b0;
  logic        wr_trigger3, busy3;
  logic [7:0]  wr_data3;
  logic [1:0]  cur_idx3;

  int total = 0;
  int bad = 0;
  int trig_total = 0;
  int ack_total = 0;

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .wr_rdy(wr_rdy), .wr_done(wr_done), .is_full(is_full),
    .wr_trigger(wr_trigger), .wr_data(wr_data), .busy(busy), .cur_idx(cur_idx)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_data(req_data3), .ack(ack3),
    .wr_rdy(wr_rdy3), .wr_done(wr_done3), .is_full(is_full3),
    .wr_trigger(wr_trigger3), .wr_data(wr_data3), .busy(busy3), .cur_idx(cur_idx3)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Writer: drops wr_rdy one cycle after the trigger starts, pulses wr_done
  // three cycles after that, then becomes ready again.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        ph = 0; wr_rdy = 1'b1; wr_done = 1'b0;
      end else begin
        case (ph)
          0: if (wr_trigger) ph = 1;
          1: begin wr_rdy = 1'b0; ph = 2; end
          2, 3: ph++;
          4: begin wr_done = 1'b1; ph = 5; end
          5: begin wr_done = 1'b0; wr_rdy = 1'b1; ph = 0; end
          default: ph = 0;
        endcase
      end
    end
  end

  // Fast writer for the 3-requester instance.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        wr_rdy3 = 1'b1; wr_done3 = 1'b0;
      end else if (wr_trigger3 && wr_rdy3) wr_rdy3 = 1'b0;
      else if (!wr_rdy3 && !wr_done3)       wr_done3 = 1'b1;
      else if (wr_done3) begin
        wr_done3 = 1'b0; wr_rdy3 = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (wr_trigger) trig_total++;
      if (ack != 2'b00) ack_total++;
    end
  end

  task automatic wait_ack2(output logic [1:0] a);
    a = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        a = ack;
        break;
      end
    end
    check_val("ack_seen", 32'(a != 2'b00), 1);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    logic [1:0] a;
    logic [2:0] a3;
    logic [1:0] e3;
    int t0, a0, seen;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_trig", 32'(wr_trigger), 0);
    check_val("rst_ack", 32'(ack), 0);
    check_val("rst_data", 32'(wr_data), 0);
    check_val("rst_idx", 32'(cur_idx), 0);
    check_val("rst_idx3", 32'(cur_idx3), 0);
    reset = 1'b0;

    // single request
    @(posedge clk); #1;
    req = 2'b01; req_data[7:0] = 8'hA5;
    t0 = trig_total; a0 = ack_total;
    @(negedge clk);
    @(negedge clk);
    check_val("s_busy_c1", 32'(busy), 1);
    check_val("s_trig_c1", 32'(wr_trigger), 0);
    check_val("s_data_c1", 32'(wr_data), 32'h A5);
    wait_ack2(a);
    check_val("s_ack", 32'(a), 32'h1);
    check_val("s_data", 32'(wr_data), 32'hA5);
    @(posedge clk); #1 req = 2'b00;
    @(negedge clk);
    check_val("s_busy_after", 32'(busy), 0);
    check_val("s_ack_after", 32'(ack), 0);
    check_val("s_trig_cycles", 32'(trig_total - t0), 2);
    check_val("s_ack_count", 32'(ack_total - a0), 1);

    // fairness with both requests held
    do_reset();
    @(posedge clk); #1;
    req = 2'b11; req_data = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      wait_ack2(a);
      check_val("f_ack", 32'(a), (i % 2) ? 32'h2 : 32'h1);
      check_val("f_idx", 32'(cur_idx), 32'(i % 2));
      check_val("f_data", 32'(wr_data), (i % 2) ? 32'h22 : 32'h11);
    end
    @(posedge clk); #1 req = 2'b00;

    // backpressure
    @(posedge clk); #1;
    is_full = 1'b1; req = 2'b01; req_data[7:0] = 8'h77;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("bp_busy", 32'(busy), 1);
      check_val("bp_trig", 32'(wr_trigger), 0);
    end
    @(posedge clk); #1 is_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("bp_trig_start", 32'(wr_trigger), 1);
    wait_ack2(a);
    check_val("bp_ack", 32'(a), 32'h1);
    check_val("bp_data", 32'(wr_data), 32'h77);
    @(posedge clk); #1 req = 2'b00;

    // withdrawal after grant, plus a request raised and dropped while busy
    @(posedge clk); #1;
    req = 2'b10; req_data[15:8] = 8'h33;
    t0 = trig_total; a0 = ack_total;
    @(posedge clk); #1;
    req = 2'b00; req_data[15:8] = 8'h00;
    @(posedge clk); #1;
    req = 2'b01; req_data[7:0] = 8'h44;
    @(posedge clk); #1;
    @(posedge clk); #1 req = 2'b00;
    wait_ack2(a);
    check_val("wd_ack", 32'(a), 32'h2);
    check_val("wd_idx", 32'(cur_idx), 1);
    check_val("wd_data", 32'(wr_data), 32'h33);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check_val("wd_no_write", 32'(seen), 0);
    check_val("wd_trig_cycles", 32'(trig_total - t0), 2);
    check_val("wd_ack_count", 32'(ack_total - a0), 1);

    // reset while in TRIGGER
    @(posedge clk); #1;
    req = 2'b01; req_data[7:0] = 8'h55;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wr_trigger) break;
    end
    check_val("mr_trig_before", 32'(wr_trigger), 1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mr_trig", 32'(wr_trigger), 0);
    check_val("mr_busy", 32'(busy), 0);
    check_val("mr_ack", 32'(ack), 0);
    check_val("mr_data", 32'(wr_data), 0);
    reset = 1'b0;
    req = 2'b11; req_data[15:8] = 8'h66;
    wait_ack2(a);
    check_val("mr_first_ack", 32'(a), 32'h1);
    check_val("mr_first_data", 32'(wr_data), 32'h55);
    wait_ack2(a);
    check_val("mr_second_ack", 32'(a), 32'h2);
    check_val("mr_second_data", 32'(wr_data), 32'h66);
    @(posedge clk); #1 req = 2'b00;

    // three requesters, wrap-around order
    @(posedge clk); #1;
    req3 = 3'b111; req_data3 = {8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 4; i++) begin
      e3 = 2'(i % 3);
      a3 = '0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (ack3 != 3'b000) begin
          a3 = ack3;
          break;
        end
      end
      check_val("w3_ack", 32'(a3), 32'(3'b001 << e3));
      check_val("w3_idx", 32'(cur_idx3), 32'(e3));
      check_val("w3_data", 32'(wr_data3), 32'(8'hA0 + 8'(e3)));
    end
    @(posedge clk); #1 req3 = 3'b000;
    repeat (3) @(negedge clk);
    check_val("w3_idle", 32'(busy3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
